// File: rtl/encoder_scan.sv
// Captures a 16-bit request vector and emits the set-bit indices one per handshake, then pulses done.
// Define ENCODER_SCAN_MSB_FIRST_EN to drain the highest set bit first (default: lowest first).
module encoder_scan (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] encoder_in,
  input  logic        load,
  output logic        ready,
  output logic [3:0]  binary_out,
  output logic        valid_out,
  input  logic        out_ready,
  output logic        done,
  output logic [4:0]  count_out
);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t      state;
  state_t      state_nxt;
  logic [15:0] pending;
  logic [15:0] pending_clr;
  logic        accept;
  logic        xfer;

  function automatic logic [3:0] prio_idx(input logic [15:0] v);
    logic [3:0] idx;
    idx = 4'h0;
`ifdef ENCODER_SCAN_MSB_FIRST_EN
    for (int i = 0; i < 16; i++)
      if (v[i]) idx = i[3:0];
`else
    for (int i = 15; i >= 0; i--)
      if (v[i]) idx = i[3:0];
`endif
    return idx;
  endfunction

  function automatic logic [4:0] popcount(input logic [15:0] v);
    logic [4:0] c;
    c = 5'd0;
    for (int i = 0; i < 16; i++)
      c = c + {4'd0, v[i]};
    return c;
  endfunction

  assign accept      = (state == IDLE) && load;
  assign xfer        = (state == SCAN) && out_ready;
  assign pending_clr = pending & ~(16'h0001 << binary_out);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (load && (encoder_in != 16'h0000)) state_nxt = SCAN;
      SCAN:    if (xfer && (pending_clr == 16'h0000)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ready     = (state == IDLE);
    valid_out = (state == SCAN);
  end

  // Datapath: pending vector, current index, popcount and the drain pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending    <= 16'h0000;
      binary_out <= 4'h0;
      count_out  <= 5'd0;
      done       <= 1'b0;
    end else if (accept) begin
      pending    <= encoder_in;
      count_out  <= popcount(encoder_in);
      binary_out <= prio_idx(encoder_in);
      done       <= (encoder_in == 16'h0000);
    end else if (xfer) begin
      pending <= pending_clr;
      if (pending_clr != 16'h0000) binary_out <= prio_idx(pending_clr);
      done    <= (pending_clr == 16'h0000);
    end else begin
      done <= 1'b0;
    end
  end

endmodule

// File: tb/tb_encoder_scan.sv
// Directed bench for encoder_scan; expectations follow the build's priority order.
module tb_encoder_scan;

  logic        clk;
  logic        reset_n;
  logic [15:0] encoder_in;
  logic        load;
  logic        ready;
  logic [3:0]  binary_out;
  logic        valid_out;
  logic        out_ready;
  logic        done;
  logic [4:0]  count_out;

  int total = 0;
  int bad   = 0;
  int exp_q[$];

  encoder_scan dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .encoder_in (encoder_in),
    .load       (load),
    .ready      (ready),
    .binary_out (binary_out),
    .valid_out  (valid_out),
    .out_ready  (out_ready),
    .done       (done),
    .count_out  (count_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [15:0] vec);
    encoder_in = vec;
    load       = 1'b1;
    tick();
    load       = 1'b0;
  endtask

  // Drains the current scan, matching indices against exp_q; optional out_ready toggling.
  task automatic drain(input bit toggle, input int exp_cnt);
    int   got;
    int   cyc;
    bit   done_seen;
    bit   stalled;
    logic [3:0] held;
    got = 0; cyc = 0; done_seen = 0;
    out_ready = 1'b1;
    while (!done_seen && cyc < 100) begin
      stalled = 0;
      held    = binary_out;
      if (valid_out && out_ready) begin
        if (got < exp_q.size()) check($sformatf("idx%0d", got), binary_out, exp_q[got]);
        else check("extra_idx", binary_out, 32'hFFFF);
        got++;
      end else if (valid_out) begin
        stalled = 1;
      end
      tick();
      if (stalled) check("stall_hold", {valid_out, binary_out}, {1'b1, held});
      if (done) begin
        done_seen = 1;
        check("done_state", {valid_out, ready}, 2'b01);
        check("count", count_out, exp_cnt);
      end
      if (toggle) out_ready = ~out_ready;
      cyc++;
    end
    check("transfers", got, exp_q.size());
    check("done_seen", done_seen, 1);
    out_ready = 1'b1;
    tick();
    check("done_pulse_end", done, 0);
  endtask

  initial begin
    reset_n    = 1'b0;
    encoder_in = 16'h0000;
    load       = 1'b0;
    out_ready  = 1'b0;
    #12;
    check("rst_ready", ready, 1);
    check("rst_valid", valid_out, 0);
    check("rst_bin", binary_out, 0);
    check("rst_done", done, 0);
    check("rst_count", count_out, 0);
    reset_n = 1'b1;
    @(negedge clk);

    // 16'h8421 drains four indices with out_ready held high
    out_ready = 1'b1;
    do_load(16'h8421);
    check("8421_valid", valid_out, 1);
    check("8421_ready", ready, 0);
    check("8421_count", count_out, 4);
`ifdef ENCODER_SCAN_MSB_FIRST_EN
    exp_q = '{15, 10, 5, 0};
`else
    exp_q = '{0, 5, 10, 15};
`endif
    drain(0, 4);

    // zero vector: no scan, done one cycle later
    do_load(16'h0000);
    check("zero_valid", valid_out, 0);
    check("zero_ready", ready, 1);
    check("zero_done", done, 1);
    check("zero_count", count_out, 0);
    tick();
    check("zero_done_end", done, 0);
    check("zero_ready2", ready, 1);

    // all ones with out_ready toggling
    do_load(16'hFFFF);
    check("ffff_count", count_out, 16);
    exp_q.delete();
`ifdef ENCODER_SCAN_MSB_FIRST_EN
    for (int i = 15; i >= 0; i--) exp_q.push_back(i);
`else
    for (int i = 0; i < 16; i++) exp_q.push_back(i);
`endif
    drain(1, 16);

    // reset in the middle of a scan of 16'h00F0
    out_ready = 1'b1;
    do_load(16'h00F0);
`ifdef ENCODER_SCAN_MSB_FIRST_EN
    check("f0_idx0", binary_out, 7);
    tick();
    check("f0_idx1", binary_out, 6);
    tick();
    check("f0_idx2", binary_out, 5);
`else
    check("f0_idx0", binary_out, 4);
    tick();
    check("f0_idx1", binary_out, 5);
    tick();
    check("f0_idx2", binary_out, 6);
`endif
    reset_n = 1'b0;
    #1;
    check("mid_rst_valid", valid_out, 0);
    check("mid_rst_ready", ready, 1);
    check("mid_rst_count", count_out, 0);
    check("mid_rst_bin", binary_out, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("mid_rst_no_done", done, 0);
    end
    @(negedge clk);
    encoder_in = 16'h0003;
    load       = 1'b1;
    reset_n    = 1'b1;
    tick();
    load = 1'b0;
    check("post_rst_valid", valid_out, 1);
    check("post_rst_count", count_out, 2);
`ifdef ENCODER_SCAN_MSB_FIRST_EN
    exp_q = '{1, 0};
`else
    exp_q = '{0, 1};
`endif
    drain(0, 2);

    // load during scan (including the final transfer cycle) is ignored
    do_load(16'h0011);
    check("ign_count", count_out, 2);
    out_ready  = 1'b0;
    load       = 1'b1;
    encoder_in = 16'hFFFF;
    tick();
`ifdef ENCODER_SCAN_MSB_FIRST_EN
    check("ign_hold", binary_out, 4);
`else
    check("ign_hold", binary_out, 0);
`endif
    check("ign_valid", valid_out, 1);
    out_ready = 1'b1;
    tick();
`ifdef ENCODER_SCAN_MSB_FIRST_EN
    check("ign_idx1", binary_out, 0);
`else
    check("ign_idx1", binary_out, 4);
`endif
    check("ign_count2", count_out, 2);
    tick();
    check("ign_final_valid", valid_out, 0);
    check("ign_final_ready", ready, 1);
    check("ign_final_done", done, 1);
    check("ign_final_count", count_out, 2);
    load = 1'b0;
    tick();
    check("ign_done_end", done, 0);
    check("ign_idle_valid", valid_out, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
